// File: rtl/inst_rom_srv_if.sv
// Fetch and loader handshake bundle between the CPU and the boot ROM server.
// "slave" is the ROM side. "master" is the CPU-fetch and loader side.
interface inst_rom_srv_if;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        ld_ready_o;

  modport slave  (input  rom_ce_i, rom_addr_i, ld_valid_i, ld_data_i,
                  output rom_data_o, ld_ready_o);
  modport master (output rom_ce_i, rom_addr_i, ld_valid_i, ld_data_i,
                  input  rom_data_o, ld_ready_o);
endinterface

// File: rtl/inst_rom_srv.sv
// Instruction ROM that holds the CPU in reset while a length-prefixed program
// streams in. It then releases the CPU and serves zero-latency fetches.
module inst_rom_srv #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  inst_rom_srv_if.slave    bus,
  output logic             cpu_rst_o,
  output logic             ld_done_o,
  output logic             ld_err_o
);
  localparam logic [31:0]   DEPTH = 32'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {HDR, LOAD, RUN, ERR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic [ADDR_W:0]   len, len_nxt;
  logic              mem_we;
  logic              xfer;
  logic              hdr_bad;
  logic [31:0]       mem [2**ADDR_W];

  assign bus.ld_ready_o = (state == HDR) || (state == LOAD);
  assign xfer           = bus.ld_valid_i && bus.ld_ready_o;
  assign hdr_bad        = (bus.ld_data_i == 32'd0) || (bus.ld_data_i > DEPTH);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len;
    mem_we    = 1'b0;
    case (state)
      HDR: if (xfer) begin
        len_nxt = bus.ld_data_i[ADDR_W:0];
        if (hdr_bad) state_nxt = ERR;
        else begin
          cnt_nxt   = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: if (xfer) begin
        mem_we  = 1'b1;
        cnt_nxt = cnt + ONE;
        if (cnt == len - ONE) state_nxt = RUN;
      end
      default: ;
    endcase
  end

  // Status outputs are flops decoded from the next state so they switch on the
  // same edge as the state and cpu_rst_o can never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HDR;
      cnt       <= '0;
      len       <= '0;
      cpu_rst_o <= 1'b1;
      ld_done_o <= 1'b0;
      ld_err_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      len       <= len_nxt;
      cpu_rst_o <= (state_nxt != RUN);
      ld_done_o <= (state_nxt == RUN);
      ld_err_o  <= (state_nxt == ERR);
    end
  end

  // Memory has no reset, so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cnt[ADDR_W-1:0]] <= bus.ld_data_i;
  end

  logic [ADDR_W-1:0] idx;
  logic              hit;
  logic [1:0]        unused_addr;

  assign idx         = bus.rom_addr_i[ADDR_W+1:2];
  assign unused_addr = bus.rom_addr_i[1:0];
  assign hit         = (state == RUN) && bus.rom_ce_i &&
                       (bus.rom_addr_i[31:ADDR_W+2] == '0) &&
                       ({1'b0, idx} < len);
  assign bus.rom_data_o = hit ? mem[idx] : NOP_WORD;
endmodule

// File: doc/inst_rom_srv.md
Name: inst_rom_srv

Overview:
- On-chip instruction memory that acts as the responder for the CPU's fetch port (rom_ce / rom_addr / rom_data).
- After reset it holds the CPU in reset. It then accepts a program over a valid/ready word stream: one length header followed by that many instruction words.
- When loading completes, it releases the CPU and serves instruction fetches.
- It sits beside the CPU core at top level and drives the core's active-high rst input.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2^ADDR_W 32-bit words.
- NOP_WORD, 32'h00000000, value returned for disabled, out-of-range or not-yet-loaded fetches.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rom_ce_i  input  1  fetch enable from the CPU.
- rom_addr_i  input  32  byte fetch address from the CPU.
- rom_data_o  output  32  fetched instruction word.
- ld_valid_i  input  1  loader word valid.
- ld_data_i  input  32  loader word: the header first, then instruction words.
- ld_ready_o  output  1  the block can accept a loader word this cycle.
- cpu_rst_o  output  1  active-high reset to the CPU core.
- ld_done_o  output  1  the program is loaded and the CPU is running.
- ld_err_o  output  1  the header was illegal; the block is locked until reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=HDR, word counter=0, length register=0.
  - cpu_rst_o=1, ld_done_o=0, ld_err_o=0.
  - Memory contents are not cleared.
- A loader transfer occurs on a rising edge where ld_valid_i=1 and ld_ready_o=1.
- ld_ready_o is 1 in HDR and LOAD only. It is a function of state only, never of ld_valid_i.

State HDR:
- On a transfer, capture len=ld_data_i.
- If len==0 or len>2^ADDR_W, go to ERR.
- Otherwise set counter=0 and go to LOAD.

State LOAD:
- Each transfer writes mem[counter]=ld_data_i and increments counter.
- The transfer that writes counter==len-1 moves the state to RUN on the same edge.
- No transfer means no change; gaps in ld_valid_i of any length are allowed.

State RUN:
- cpu_rst_o=0 and ld_done_o=1, both registered; they change on the same edge that enters RUN.
- ld_valid_i is ignored and no memory writes occur.
- RUN is left only by reset.

State ERR:
- ld_err_o=1, cpu_rst_o=1, ld_ready_o=0.
- ERR is left only by reset.

Fetch path (combinational, zero latency):
- The CPU's fetch pipeline register captures the result.
- The word index is rom_addr_i[ADDR_W+1:2]; rom_addr_i[1:0] is ignored.
- rom_data_o = mem[index] only when all of the following hold:
  - state==RUN;
  - rom_ce_i==1;
  - rom_addr_i[31:ADDR_W+2]==0;
  - index < len.
- Otherwise rom_data_o=NOP_WORD. This covers reset, HDR, LOAD, ERR, ce low, high addresses, and words beyond the loaded length.

Other rules:
- Reset in the middle of a load returns to HDR. Previously written words stay in memory but are unreachable until the next full load completes, because len is reset to 0.
- Counter width is ADDR_W+1 so that len==2^ADDR_W terminates without wrap-around.
- cpu_rst_o is glitch-free: it is driven directly from a flop.
- The memory is single-write, single-read, and maps to distributed or block RAM with a combinational read.

Test Plan:
- Basic load and fetch:
  - Reset, then stream header 3 and words 0x34011100, 0x34020020, 0x3403ff00.
  - Required: ld_ready_o=1 throughout; cpu_rst_o falls and ld_done_o rises on the edge accepting the 3rd word.
  - Then fetch addr 0x0/0x4/0x8 with ce=1: returns the three words. Fetch addr 0xC: returns 0x00000000.
- Handshake gaps:
  - Same program with ld_valid_i low for 5 cycles between each word.
  - Required: the counter advances only on valid cycles; the same final contents and completion occur after the 3rd accepted word.
- Illegal headers:
  - Header 0: ld_err_o=1 next edge, ld_ready_o=0, cpu_rst_o stays 1, all fetches return 0.
  - After reset, header 1025 (ADDR_W=10): same response.
  - After reset, header 1024 followed by 1024 words: RUN reached; fetch 0xFFC returns the last word.
- Fetch gating in RUN:
  - rom_ce_i=0 at addr 0x4: returns 0.
  - Addr 0x00001004 (above depth): returns 0.
  - Addr 0x5 (misaligned): returns the word at index 1.
- Reset mid-load:
  - Load header 4 with 2 words, then pulse rst low asynchronously between edges.
  - Required: cpu_rst_o=1, state HDR, ld_done_o=0 immediately.
  - Then load header 1 with 0xAABBCCDD: addr 0 returns 0xAABBCCDD and addr 4 returns 0.
- Post-run immunity:
  - In RUN, drive ld_valid_i=1 with ld_data_i=0xFFFFFFFF for 10 cycles.
  - Required: ld_ready_o=0, memory unchanged, ld_done_o stays 1, cpu_rst_o stays 0.
